// File: rtl/gpio_debounce_if.sv
// Wishbone pipelined slave bus for the GPIO debouncer register block.
// Signal names follow the pad-side naming of the debouncer's port list.
interface gpio_debounce_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_data
    );
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin debouncer: 2-flop synchronizer, saturating counter against a shared limit,
// sticky change flags with W1C clear and an OR-reduced registered interrupt.
module gpio_debounce #(
    parameter int                NIN           = 16,
    parameter int                CW            = 16,
    parameter logic [NIN-1:0]    DEFAULT_IN    = '0,
    parameter logic [CW-1:0]     DEFAULT_LIMIT = CW'(32'd1000)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    gpio_debounce_if.slave       wb,
    input  logic [NIN-1:0]       i_gpio,
    output logic [NIN-1:0]       o_gpio,
    output logic                 o_int
);

    logic [NIN-1:0] sync1_q, sync1_d;
    logic [NIN-1:0] sync2_q, sync2_d;
    logic [NIN-1:0] gpio_q, gpio_d;
    logic [NIN-1:0] sticky_q, sticky_d;
    logic [CW-1:0]  cnt_q [NIN];
    logic [CW-1:0]  cnt_d [NIN];
    logic [CW-1:0]  limit_q, limit_d;
    logic           ack_q, ack_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           int_q, int_d;

    logic [NIN-1:0] event_s;
    logic [NIN-1:0] clr_s;
    logic           wr_s;
    logic [15:0]    gpio16_s;
    logic [15:0]    sticky16_s;
    logic [31:0]    limit32_s;
    logic           unused_s;

    assign unused_s = &{1'b0, wb.i_wb_cyc, wb.i_wb_sel, wb.i_wb_data};

    // Counter saturates at the limit: a mismatch seen with cnt >= limit commits the new level.
    always_comb begin
        sync1_d = i_gpio;
        sync2_d = sync1_q;
        gpio_d  = gpio_q;
        event_s = '0;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != gpio_q[i]) begin
                if (cnt_q[i] >= limit_q) begin
                    gpio_d[i]  = sync2_q[i];
                    cnt_d[i]   = '0;
                    event_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1'b1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Register writes, sticky update (set beats clear) and read-data capture.
    always_comb begin
        wr_s = wb.i_wb_stb & wb.i_wb_we;
        if (wr_s && !wb.i_wb_addr) begin
            limit_d = wb.i_wb_data[CW-1:0];
            clr_s   = '0;
        end else if (wr_s && wb.i_wb_addr) begin
            limit_d = limit_q;
            clr_s   = wb.i_wb_data[NIN-1:0];
        end else begin
            limit_d = limit_q;
            clr_s   = '0;
        end
        sticky_d = (sticky_q & ~clr_s) | event_s;
        int_d    = |sticky_q;
        ack_d    = wb.i_wb_stb;

        gpio16_s               = 16'h0000;
        gpio16_s[NIN-1:0]      = gpio_q;
        sticky16_s             = 16'h0000;
        sticky16_s[NIN-1:0]    = sticky_q;
        limit32_s              = 32'h0000_0000;
        limit32_s[CW-1:0]      = limit_q;

        if (wb.i_wb_stb) begin
            rdata_d = wb.i_wb_addr ? {gpio16_s, sticky16_s} : limit32_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q  <= DEFAULT_IN;
            sync2_q  <= DEFAULT_IN;
            gpio_q   <= DEFAULT_IN;
            sticky_q <= '0;
            limit_q  <= DEFAULT_LIMIT;
            ack_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            int_q    <= 1'b0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            gpio_q   <= gpio_d;
            sticky_q <= sticky_d;
            limit_q  <= limit_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            int_q    <= int_d;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_gpio        = gpio_q;
    assign o_int         = int_q;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_data  = rdata_q;

endmodule
